trace_decoder: RTL and testbench
================================

// Module: trace_decoder
// PURPOSE
//  Receive end of the 18-bit trace word stream produced by the trace encoder.
//  Parses framed half-word records back into 32-bit words with kind/flags and SOF/EOF.
//  Buffers them in a show-ahead FIFO behind a valid/ready interface for the trace
//  capture/DMA path, and raises trigger markers, overflow and protocol-error status.
// PARAMETERS
//  C_FIFO_DEPTH  16  output FIFO entries; power of 2, 4..64
//  C_MAX_WORDS   8   max 32-bit words per record; 1..15
// PORTS
//  Clk          in   1   single clock; all logic on rising edge
//  Rst_n        in   1   reset, asynchronous assert, active-low
//  Enc_data     in   18  trace word: [0:1] type, [2:17] payload (bit 2 = MSB)
//  Enc_collect  in   1   Enc_data valid this cycle; no backpressure toward encoder
//  Out_data     out  32  decoded word (high half first on the wire)
//  Out_kind     out  4   record kind from header
//  Out_flags    out  8   record flags from header
//  Out_sof      out  1   first word of record
//  Out_eof      out  1   last word of record
//  Out_valid    out  1   FIFO non-empty
//  Out_ready    in   1   consumer accepts; pop when Out_valid & Out_ready
//  Trigger_out  out  1   1-cycle pulse per TRIG word
//  Overflow     out  1   sticky: word lost because FIFO full
//  Proto_err    out  1   sticky: malformed stream
//  Err_clr      in   1   clears Overflow and Proto_err
//  Rec_count    out  16  complete records pushed; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM in S_IDLE, counters 0.
//  Word types (only when Enc_collect=1):
//   00 IDLE: no effect in any state; gaps allowed mid-record.
//   01 HDR: payload[15:12]=kind, [11:8]=nwords, [7:0]=flags.
//   10 DATA: 16-bit half-word. 11 TRIG: payload ignored.
//  FSM states S_IDLE, S_HI, S_LO, S_DROP:
//   S_IDLE: HDR with 1<=nwords<=C_MAX_WORDS -> latch kind/flags/nwords, S_HI.
//     Invalid nwords (0 or >C_MAX_WORDS): set Proto_err, stay. DATA: set Proto_err, drop.
//   S_HI: DATA -> latch high half, S_LO.
//   S_LO: DATA -> form {hi,lo}, push entry, decrement remaining words.
//     0 remaining -> eof=1, S_IDLE. Else S_HI.
//   HDR in S_HI/S_LO: truncation; set Proto_err, discard partial half, process as new header.
//     Words already pushed stay; no EOF is emitted for them.
//   S_DROP: entered when push hits full FIFO; Overflow set.
//     Consume remaining DATA silently, then S_IDLE. HDR exits early, no error.
//  TRIG in any state: Trigger_out=1 next cycle; FSM state unchanged.
//  Push: sof=1 on first word of record; Rec_count++ on push with eof=1.
//  Latency: low half accepted cycle N -> Out_valid/Out_data valid cycle N+1 if FIFO was empty.
//  FIFO full with push and pop in same cycle: push accepted, no overflow.
//  Output fields hold while Out_valid & !Out_ready.
//  Err_clr with a same-cycle error event: set wins.
//  Rst_n low mid-record: FIFO flushed, partial record lost, no flags.
// TESTING
//  HDR kind=3,n=2,flags=A5; DATA 1234,5678,9ABC,DEF0; ready=1 ->
//    two words: 12345678 (sof), 9ABCDEF0 (eof), kind 3, flags A5; Rec_count=1.
//  Same record with IDLE words between halves and Enc_collect=0 gaps -> identical output.
//  Out_ready=0, push C_FIFO_DEPTH+1 one-word records -> 16 held, Overflow=1,
//    17th lost; drain shows 16 in order.
//  HDR n=3, 2 DATA, then HDR n=1 + 2 DATA -> Proto_err=1;
//    second record is one word with sof=eof=1.
//  DATA with no header; HDR n=0 -> Proto_err=1, no FIFO push; Err_clr -> 0.
//  TRIG between halves of a word -> Trigger_out one-cycle pulse; word still decodes correctly.

Source files
------------

// File: rtl/trace_decoder.sv
// Receive side of the trace word stream: rebuilds framed half-word records
// into 32-bit words, buffers them in a show-ahead FIFO and reports status.
//
// Ports:
//   Clk, Rst_n    clock, async active-low reset
//   Enc_data      [17:16] word type, [15:0] payload (MSB first on the wire)
//   Enc_collect   Enc_data valid this cycle (no backpressure)
//   Out_*         FIFO head: data/kind/flags/sof/eof, valid/ready handshake
//   Trigger_out   one-cycle pulse per TRIG word
//   Overflow      sticky, word lost on a full FIFO
//   Proto_err     sticky, malformed stream
//   Err_clr       clears Overflow and Proto_err
//   Rec_count     complete records pushed (wraps)

module trace_decoder #(
   parameter int C_FIFO_DEPTH = 16,
   parameter int C_MAX_WORDS  = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [17:0] Enc_data,
   input  logic        Enc_collect,
   output logic [31:0] Out_data,
   output logic [3:0]  Out_kind,
   output logic [7:0]  Out_flags,
   output logic        Out_sof,
   output logic        Out_eof,
   output logic        Out_valid,
   input  logic        Out_ready,
   output logic        Trigger_out,
   output logic        Overflow,
   output logic        Proto_err,
   input  logic        Err_clr,
   output logic [15:0] Rec_count
);

   localparam int AW = $clog2(C_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0]    MAX_N    = 4'(C_MAX_WORDS);
   localparam logic [CW-1:0] FULL_CNT = CW'(C_FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_DROP
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  kind;
      logic [7:0]  flags;
      logic        sof;
      logic        eof;
   } entry_t;

   // record context
   state_t      state;
   logic [15:0] hi_half;
   logic [3:0]  kind_q;
   logic [7:0]  flags_q;
   logic [3:0]  left_q;
   logic        first_q;
   logic [4:0]  drop_q;

   // FIFO storage
   entry_t        mem [C_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // word decode
   logic [1:0]  wtype;
   logic [15:0] payload;
   logic        is_hdr;
   logic        is_data;
   logic        is_trig;
   logic [3:0]  hdr_n;
   logic        hdr_ok;

   assign wtype   = Enc_data[17:16];
   assign payload = Enc_data[15:0];
   assign is_hdr  = Enc_collect & (wtype == 2'b01);
   assign is_data = Enc_collect & (wtype == 2'b10);
   assign is_trig = Enc_collect & (wtype == 2'b11);
   assign hdr_n   = payload[11:8];
   assign hdr_ok  = (hdr_n != 4'd0) && (hdr_n <= MAX_N);

   // push / pop arbitration
   logic   full;
   logic   pop;
   logic   push_req;
   logic   push;
   logic   lost;
   logic   last_word;
   logic   proto_set;
   entry_t new_entry;
   entry_t head;

   assign full      = (count == FULL_CNT);
   assign pop       = Out_valid & Out_ready;
   assign push_req  = is_data & (state == S_LO);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push      = push_req & (~full | pop);
   assign lost      = push_req & full & ~pop;
   assign last_word = (left_q == 4'd1);

   assign new_entry = '{
      data:  {hi_half, payload},
      kind:  kind_q,
      flags: flags_q,
      sof:   first_q,
      eof:   last_word
   };

   // header mid-word or mid-record is a truncation
   assign proto_set = (is_data & (state == S_IDLE))
                    | (is_hdr & ~hdr_ok)
                    | (is_hdr & ((state == S_HI) | (state == S_LO)));

   // record FSM and status outputs
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= S_IDLE;
         hi_half     <= '0;
         kind_q      <= '0;
         flags_q     <= '0;
         left_q      <= '0;
         first_q     <= 1'b0;
         drop_q      <= '0;
         Trigger_out <= 1'b0;
         Overflow    <= 1'b0;
         Proto_err   <= 1'b0;
         Rec_count   <= '0;
      end else begin
         Trigger_out <= is_trig;
         // a same-cycle error event beats the clear
         Overflow    <= lost | (Overflow & ~Err_clr);
         Proto_err   <= proto_set | (Proto_err & ~Err_clr);

         if (push && last_word) begin
            Rec_count <= Rec_count + 16'd1;
         end

         unique case (1'b1)
            is_hdr: begin
               if (hdr_ok) begin
                  kind_q  <= payload[15:12];
                  flags_q <= payload[7:0];
                  left_q  <= hdr_n;
                  first_q <= 1'b1;
                  state   <= S_HI;
               end else begin
                  state   <= S_IDLE;
               end
            end
            is_data: begin
               unique case (state)
                  S_IDLE: begin
                  end
                  S_HI: begin
                     hi_half <= payload;
                     state   <= S_LO;
                  end
                  S_LO: begin
                     left_q <= left_q - 4'd1;
                     if (lost) begin
                        // skip both halves of every word still owed
                        drop_q <= {left_q - 4'd1, 1'b0};
                        state  <= last_word ? S_IDLE : S_DROP;
                     end else begin
                        first_q <= 1'b0;
                        state   <= last_word ? S_IDLE : S_HI;
                     end
                  end
                  S_DROP: begin
                     drop_q <= drop_q - 5'd1;
                     if (drop_q == 5'd1) begin
                        state <= S_IDLE;
                     end
                  end
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   // show-ahead head; fields read as zero while empty
   assign head      = mem[rd_ptr];
   assign Out_valid = (count != '0);
   assign Out_data  = Out_valid ? head.data  : '0;
   assign Out_kind  = Out_valid ? head.kind  : '0;
   assign Out_flags = Out_valid ? head.flags : '0;
   assign Out_sof   = Out_valid & head.sof;
   assign Out_eof   = Out_valid & head.eof;

endmodule

// File: tb/tb_trace_decoder.sv
// Self-checking bench for trace_decoder: vector table, directed
// sequences and a randomized run against a record-level model.

module tb_trace_decoder;

   localparam int DEPTH = 16;
   localparam int MAXW  = 8;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic [17:0] Enc_data = '0;
   logic        Enc_collect = 1'b0;
   logic [31:0] Out_data;
   logic [3:0]  Out_kind;
   logic [7:0]  Out_flags;
   logic        Out_sof;
   logic        Out_eof;
   logic        Out_valid;
   logic        Out_ready = 1'b0;
   logic        Trigger_out;
   logic        Overflow;
   logic        Proto_err;
   logic        Err_clr = 1'b0;
   logic [15:0] Rec_count;

   trace_decoder #(
      .C_FIFO_DEPTH(DEPTH),
      .C_MAX_WORDS (MAXW)
   ) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Enc_data   (Enc_data),
      .Enc_collect(Enc_collect),
      .Out_data   (Out_data),
      .Out_kind   (Out_kind),
      .Out_flags  (Out_flags),
      .Out_sof    (Out_sof),
      .Out_eof    (Out_eof),
      .Out_valid  (Out_valid),
      .Out_ready  (Out_ready),
      .Trigger_out(Trigger_out),
      .Overflow   (Overflow),
      .Proto_err  (Proto_err),
      .Err_clr    (Err_clr),
      .Rec_count  (Rec_count)
   );

   always #5 Clk = ~Clk;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_HDR  = 2'b01;
   localparam logic [1:0] T_DATA = 2'b10;
   localparam logic [1:0] T_TRIG = 2'b11;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic [7:0]  f;
      logic        s;
      logic        e;
   } ent_t;

   // record-level reference model
   ent_t        mq[$];
   ent_t        got[$];
   bit          m_in_rec;
   bit          m_have_hi;
   bit          m_first;
   int          m_left;
   int          m_drop;
   logic [15:0] m_hi;
   logic [3:0]  m_kind;
   logic [7:0]  m_flags;
   bit          m_ovf;
   bit          m_proto;
   bit          m_trig;
   logic [15:0] m_rec;

   task automatic model_reset();
      mq.delete();
      got.delete();
      m_in_rec  = 0;
      m_have_hi = 0;
      m_first   = 0;
      m_left    = 0;
      m_drop    = 0;
      m_hi      = '0;
      m_kind    = '0;
      m_flags   = '0;
      m_ovf     = 0;
      m_proto   = 0;
      m_trig    = 0;
      m_rec     = '0;
   endtask

   function automatic ent_t dut_head();
      return '{d: Out_data, k: Out_kind, f: Out_flags,
               s: Out_sof, e: Out_eof};
   endfunction

   // drive one cycle at a negedge, check the model, advance it
   task automatic step(input bit col, input logic [1:0] typ,
                       input logic [15:0] pl, input bit rdy,
                       input bit clr);
      bit   e_proto;
      bit   e_ovf;
      bit   pop;
      int   n;
      ent_t w;
      Enc_collect = col;
      Enc_data    = {typ, pl};
      Out_ready   = rdy;
      Err_clr     = clr;

      check("valid", 64'(Out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("head", 64'(dut_head()), 64'(mq[0]));
      end
      check("trig", 64'(Trigger_out), 64'(m_trig));
      check("ovf", 64'(Overflow), 64'(m_ovf));
      check("proto", 64'(Proto_err), 64'(m_proto));
      check("rec_count", 64'(Rec_count), 64'(m_rec));

      pop = (mq.size() != 0) && rdy;
      if (pop) begin
         got.push_back(dut_head());
         void'(mq.pop_front());
      end
      e_proto = 0;
      e_ovf   = 0;
      m_trig  = col && (typ == T_TRIG);
      if (col && typ == T_HDR) begin
         n = int'(pl[11:8]);
         if (m_in_rec) e_proto = 1;
         m_drop    = 0;
         m_have_hi = 0;
         if (n >= 1 && n <= MAXW) begin
            m_in_rec = 1;
            m_left   = n;
            m_first  = 1;
            m_kind   = pl[15:12];
            m_flags  = pl[7:0];
         end else begin
            e_proto  = 1;
            m_in_rec = 0;
         end
      end else if (col && typ == T_DATA) begin
         if (m_drop > 0) begin
            m_drop--;
         end else if (!m_in_rec) begin
            e_proto = 1;
         end else if (!m_have_hi) begin
            m_hi      = pl;
            m_have_hi = 1;
         end else begin
            w = '{d: {m_hi, pl}, k: m_kind, f: m_flags,
                  s: m_first, e: (m_left == 1)};
            m_have_hi = 0;
            if (mq.size() < DEPTH) begin
               mq.push_back(w);
               if (w.e) m_rec++;
               m_first = 0;
               m_left--;
               if (m_left == 0) m_in_rec = 0;
            end else begin
               e_ovf    = 1;
               m_drop   = 2 * (m_left - 1);
               m_in_rec = 0;
            end
         end
      end
      m_proto = e_proto || (m_proto && !clr);
      m_ovf   = e_ovf || (m_ovf && !clr);
      @(negedge Clk);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, T_IDLE, 16'h0, rdy, 0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst_n       = 1'b0;
      Enc_collect = 1'b0;
      Enc_data    = '0;
      Out_ready   = 1'b0;
      Err_clr     = 1'b0;
      @(negedge Clk);
      check("rst_bits", 64'({Out_valid, Out_sof, Out_eof, Trigger_out,
                             Overflow, Proto_err}), 64'(0));
      check("rst_data", 64'({Out_data, Out_kind, Out_flags}), 64'(0));
      check("rst_count", 64'(Rec_count), 64'(0));
      Rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit          col;
      logic [1:0]  typ;
      logic [15:0] pl;
      bit          rdy;
      bit          clr;
      bit          ev;
      logic [31:0] ed;
      bit          es;
      bit          ee;
      logic [3:0]  ek;
      logic [7:0]  ef;
      bit          et;
      bit          ep;
      logic [15:0] er;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int rp;
      tbl[0]  = '{1, T_HDR,  16'h32A5, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd0};
      tbl[1]  = '{1, T_DATA, 16'h1234, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd0};
      tbl[2]  = '{1, T_DATA, 16'h5678, 1, 0, 1, 32'h12345678, 1, 0, 4'h3, 8'hA5, 0, 0, 16'd0};
      tbl[3]  = '{1, T_DATA, 16'h9ABC, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd0};
      tbl[4]  = '{1, T_DATA, 16'hDEF0, 1, 0, 1, 32'h9ABCDEF0, 0, 1, 4'h3, 8'hA5, 0, 0, 16'd1};
      tbl[5]  = '{0, T_IDLE, 16'h0000, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd1};
      tbl[6]  = '{1, T_TRIG, 16'h5555, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 1, 0, 16'd1};
      tbl[7]  = '{0, T_IDLE, 16'h0000, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd1};
      tbl[8]  = '{1, T_HDR,  16'h1000, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 1, 16'd1};
      tbl[9]  = '{0, T_IDLE, 16'h0000, 1, 1, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd1};
      tbl[10] = '{1, T_DATA, 16'hFFFF, 1, 0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 1, 16'd1};
      tbl[11] = '{1, T_IDLE, 16'h1234, 1, 1, 0, 32'h0, 0, 0, 4'h0, 8'h00, 0, 0, 16'd1};

      do_reset();

      // vector table
      for (int i = 0; i < 12; i++) begin
         Enc_collect = tbl[i].col;
         Enc_data    = {tbl[i].typ, tbl[i].pl};
         Out_ready   = tbl[i].rdy;
         Err_clr     = tbl[i].clr;
         @(negedge Clk);
         check($sformatf("tbl%0d_valid", i), 64'(Out_valid), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            check($sformatf("tbl%0d_word", i),
                  64'({Out_data, Out_kind, Out_flags, Out_sof, Out_eof}),
                  64'({tbl[i].ed, tbl[i].ek, tbl[i].ef, tbl[i].es, tbl[i].ee}));
         end
         check($sformatf("tbl%0d_trig", i), 64'(Trigger_out), 64'(tbl[i].et));
         check($sformatf("tbl%0d_proto", i), 64'(Proto_err), 64'(tbl[i].ep));
         check($sformatf("tbl%0d_count", i), 64'(Rec_count), 64'(tbl[i].er));
      end

      // gaps, idles, uncollected junk and a TRIG between halves
      do_reset();
      step(1, T_HDR,  16'h32A5, 1, 0);
      step(1, T_IDLE, 16'hFFFF, 1, 0);
      step(0, T_DATA, 16'hBEEF, 1, 0);
      step(1, T_DATA, 16'h1234, 1, 0);
      step(1, T_TRIG, 16'h0000, 1, 0);
      step(1, T_IDLE, 16'h0000, 1, 0);
      step(1, T_DATA, 16'h5678, 1, 0);
      step(0, T_HDR,  16'h1100, 1, 0);
      step(1, T_DATA, 16'h9ABC, 1, 0);
      step(1, T_TRIG, 16'h0000, 1, 0);
      step(1, T_DATA, 16'hDEF0, 1, 0);
      idle(3, 1);
      check("gap_npop", 64'(got.size()), 64'(2));
      if (got.size() == 2) begin
         check("gap_w0", 64'(got[0]), 64'({32'h12345678, 4'h3, 8'hA5, 2'b10}));
         check("gap_w1", 64'(got[1]), 64'({32'h9ABCDEF0, 4'h3, 8'hA5, 2'b01}));
      end
      check("gap_count", 64'(Rec_count), 64'(1));

      // overflow: DEPTH+1 one-word records with no consumer
      do_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         step(1, T_HDR,  {4'h1, 4'h1, 8'(i)}, 0, 0);
         step(1, T_DATA, 16'h0000, 0, 0);
         step(1, T_DATA, 16'(i), 0, 0);
      end
      idle(1, 0);
      check("ovf_flag", 64'(Overflow), 64'(1));
      check("ovf_count", 64'(Rec_count), 64'(DEPTH));
      idle(DEPTH + 4, 1);
      check("ovf_npop", 64'(got.size()), 64'(DEPTH));
      for (int i = 0; i < got.size(); i++) begin
         check($sformatf("ovf_w%0d", i), 64'(got[i]),
               64'({32'(i), 4'h1, 8'(i), 2'b11}));
      end

      // full FIFO with push and pop in the same cycle
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         step(1, T_HDR,  16'h1100, 0, 0);
         step(1, T_DATA, 16'h0000, 0, 0);
         step(1, T_DATA, 16'(i), 0, 0);
      end
      step(1, T_HDR,  16'h1100, 0, 0);
      step(1, T_DATA, 16'h0000, 0, 0);
      step(1, T_DATA, 16'(DEPTH), 1, 0);
      idle(1, 0);
      check("fullpop_ovf", 64'(Overflow), 64'(0));
      check("fullpop_count", 64'(Rec_count), 64'(DEPTH + 1));
      idle(DEPTH + 4, 1);
      check("fullpop_npop", 64'(got.size()), 64'(DEPTH + 1));
      if (got.size() == DEPTH + 1) begin
         check("fullpop_last", 64'(got[DEPTH].d), 64'(DEPTH));
      end

      // truncated record followed by a new header
      do_reset();
      step(1, T_HDR,  16'h1301, 1, 0);
      step(1, T_DATA, 16'hAAAA, 1, 0);
      step(1, T_DATA, 16'hBBBB, 1, 0);
      step(1, T_HDR,  16'h2102, 1, 0);
      step(1, T_DATA, 16'hCCCC, 1, 0);
      step(1, T_DATA, 16'hDDDD, 1, 0);
      idle(3, 1);
      check("trunc_proto", 64'(Proto_err), 64'(1));
      check("trunc_npop", 64'(got.size()), 64'(2));
      if (got.size() == 2) begin
         check("trunc_w0", 64'(got[0]), 64'({32'hAAAABBBB, 4'h1, 8'h01, 2'b10}));
         check("trunc_w1", 64'(got[1]), 64'({32'hCCCCDDDD, 4'h2, 8'h02, 2'b11}));
      end
      check("trunc_count", 64'(Rec_count), 64'(1));

      // error set beats a same-cycle clear, then a plain clear
      step(1, T_DATA, 16'h1111, 1, 1);
      check("setwins", 64'(Proto_err), 64'(1));
      step(0, T_IDLE, 16'h0000, 1, 1);
      check("clr", 64'(Proto_err), 64'(0));
      idle(1, 1);

      // reset in the middle of a record
      step(1, T_HDR,  16'h1200, 0, 0);
      step(1, T_DATA, 16'h0001, 0, 0);
      step(1, T_DATA, 16'h0002, 0, 0);
      step(1, T_DATA, 16'h0003, 0, 0);
      do_reset();
      step(1, T_DATA, 16'h0004, 1, 0);
      idle(2, 1);
      check("rstmid_empty", 64'(got.size()), 64'(0));

      // randomized stream
      do_reset();
      rp = 100;
      for (int i = 0; i < 4000; i++) begin
         int          sel;
         logic [1:0]  typ;
         logic [15:0] pl;
         bit          col;
         bit          rdy;
         if (i % 250 == 0) rp = $urandom_range(0, 100);
         col = ($urandom_range(0, 99) < 85);
         sel = $urandom_range(0, 9);
         pl  = 16'($urandom_range(0, 65535));
         if (sel == 0) begin
            typ = T_IDLE;
         end else if (sel <= 2) begin
            typ = T_HDR;
            if ($urandom_range(0, 3) == 0) pl[11:8] = 4'($urandom_range(0, 15));
            else pl[11:8] = 4'($urandom_range(1, 3));
         end else if (sel <= 8) begin
            typ = T_DATA;
         end else begin
            typ = T_TRIG;
         end
         rdy = ($urandom_range(0, 99) < rp);
         step(col, typ, pl, rdy, ($urandom_range(0, 49) == 0));
      end
      idle(DEPTH + 4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
